// File: rtl/tug_game_ctrl.sv
// Tug-of-war game controller: button conditioning, countdown sequencing, live play
// and win-screen hold. Drives a registered 6-bit screen code for the display stage.
module tug_game_ctrl #(
  parameter int unsigned TICK_DIV  = 12000000,
  parameter int unsigned START_POS = 23,
  parameter int unsigned P1_WIN    = 16,
  parameter int unsigned P2_WIN    = 30,
  parameter int unsigned WIN_HOLD  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_btn,
  input  logic       p2_btn,
  input  logic       start_btn,
  output logic [5:0] screen,
  output logic [1:0] winner,
  output logic       playing
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (WIN_HOLD > 0) ? $clog2(WIN_HOLD + 1) : 1;

  localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HoldLast = HW'(WIN_HOLD);
  localparam logic [5:0]    ScrStart = 6'(START_POS);
  localparam logic [5:0]    ScrP1    = 6'(P1_WIN);
  localparam logic [5:0]    ScrP2    = 6'(P2_WIN);
  localparam logic [5:0]    ScrGo    = 6'd31;
  localparam logic [5:0]    ScrOne   = 6'd32;
  localparam logic [5:0]    ScrTwo   = 6'd33;
  localparam logic [5:0]    ScrThree = 6'd34;

  typedef enum logic [2:0] {
    StIdle, StCd3, StCd2, StCd1, StGo, StPlay, StWin1, StWin2
  } state_e;

  state_e        state;
  logic [2:0]    p1_sync, p2_sync, st_sync;
  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic          p1_press, p2_press, start_press, tick;
  logic [5:0]    next_pos;
  logic [HW-1:0] hold_inc;

  // Bits [1:0] form the synchroniser; bit 2 is the edge-detect history flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_sync <= '0;
      p2_sync <= '0;
      st_sync <= '0;
    end else begin
      p1_sync <= {p1_sync[1:0], p1_btn};
      p2_sync <= {p2_sync[1:0], p2_btn};
      st_sync <= {st_sync[1:0], start_btn};
    end
  end

  assign p1_press    = p1_sync[1] & ~p1_sync[2];
  assign p2_press    = p2_sync[1] & ~p2_sync[2];
  assign start_press = st_sync[1] & ~st_sync[2];
  assign tick        = (tick_cnt == TickLast);
  assign hold_inc    = hold_cnt + HW'(1);

  always_comb begin
    next_pos = screen;
    if (p1_press && !p2_press) begin
      next_pos = screen - 6'd1;
    end else if (p2_press && !p1_press) begin
      next_pos = screen + 6'd1;
    end
  end

  // Every state change also clears tick_cnt so each timed state spans TICK_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      screen   <= ScrStart;
      winner   <= 2'b00;
      playing  <= 1'b0;
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      unique case (state)
        StIdle: begin
          if (start_press) begin
            state    <= StCd3;
            screen   <= ScrThree;
            tick_cnt <= '0;
          end
        end
        StCd3: begin
          if (tick) begin
            state  <= StCd2;
            screen <= ScrTwo;
          end
        end
        StCd2: begin
          if (tick) begin
            state  <= StCd1;
            screen <= ScrOne;
          end
        end
        StCd1: begin
          if (tick) begin
            state  <= StGo;
            screen <= ScrGo;
          end
        end
        StGo: begin
          if (tick) begin
            state   <= StPlay;
            screen  <= ScrStart;
            playing <= 1'b1;
          end
        end
        StPlay: begin
          screen <= next_pos;
          if (next_pos == ScrP1) begin
            state    <= StWin1;
            winner   <= 2'b01;
            playing  <= 1'b0;
            tick_cnt <= '0;
          end else if (next_pos == ScrP2) begin
            state    <= StWin2;
            winner   <= 2'b10;
            playing  <= 1'b0;
            tick_cnt <= '0;
          end
        end
        StWin1, StWin2: begin
          if (start_press || (tick && hold_inc == HoldLast)) begin
            state    <= StIdle;
            screen   <= ScrStart;
            winner   <= 2'b00;
            hold_cnt <= '0;
            tick_cnt <= '0;
          end else if (tick) begin
            hold_cnt <= hold_inc;
          end
        end
        default: begin
          state    <= StIdle;
          screen   <= ScrStart;
          winner   <= 2'b00;
          playing  <= 1'b0;
          hold_cnt <= '0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Bench for tug_game_ctrl: a cycle-level game model checked every clock, plus directed
// scenarios with literal expectations at known cycle offsets.
module tb_tug_game_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned WH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p1_btn = 1'b0;
  logic       p2_btn = 1'b0;
  logic       start_btn = 1'b0;
  logic [5:0] screen;
  logic [1:0] winner;
  logic       playing;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tug_game_ctrl #(
    .TICK_DIV (TD),
    .START_POS(23),
    .P1_WIN   (16),
    .P2_WIN   (30),
    .WIN_HOLD (WH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .p1_btn   (p1_btn),
    .p2_btn   (p2_btn),
    .start_btn(start_btn),
    .screen   (screen),
    .winner   (winner),
    .playing  (playing)
  );

  // Model: mode 0 idle, 1 countdown, 2 play, 3 win; m_t counts cycles spent in the mode.
  int m_mode, m_t, m_pos, m_win;
  bit h1[3], h2[3], hs[3];

  function automatic void model_reset();
    m_mode = 0; m_t = 0; m_pos = 23; m_win = 0;
    for (int i = 0; i < 3; i++) begin
      h1[i] = 1'b0; h2[i] = 1'b0; hs[i] = 1'b0;
    end
  endfunction

  // A raw level first seen high two edges ago, and low the edge before that, is a press now.
  function automatic void model_step();
    bit a, b, s;
    a = h1[1] & ~h1[2];
    b = h2[1] & ~h2[2];
    s = hs[1] & ~hs[2];
    h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = p1_btn;
    h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = p2_btn;
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start_btn;
    case (m_mode)
      0: if (s) begin m_mode = 1; m_t = 0; end
      1: begin
        m_t++;
        if (m_t == 4 * TD) begin m_mode = 2; m_pos = 23; end
      end
      2: begin
        if (a && !b) m_pos--;
        else if (b && !a) m_pos++;
        if (m_pos == 16) begin m_mode = 3; m_win = 1; m_t = 0; end
        else if (m_pos == 30) begin m_mode = 3; m_win = 2; m_t = 0; end
      end
      default: begin
        m_t++;
        if (s || m_t == TD * WH) begin m_mode = 0; m_win = 0; m_pos = 23; end
      end
    endcase
  endfunction

  function automatic int exp_screen();
    case (m_mode)
      0: return 23;
      1: return 34 - m_t / TD;
      2: return m_pos;
      default: return (m_win == 1) ? 16 : 30;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_step();
    #1;
    check("model_screen", int'(screen), exp_screen());
    check("model_winner", int'(winner), (m_mode == 3) ? m_win : 0);
    check("model_playing", int'(playing), (m_mode == 2) ? 1 : 0);
  end

  task automatic press(input bit a, input bit b, input bit s);
    @(negedge clk);
    p1_btn = a; p2_btn = b; start_btn = s;
    @(negedge clk);
    p1_btn = 1'b0; p2_btn = 1'b0; start_btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_game(input bit noisy);
    int n;
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
    if (noisy) begin
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b1, 1'b0);
      press(1'b0, 1'b0, 1'b1);
    end
    n = 0;
    while (!playing && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("countdown_done", int'(playing), 1);
    check("play_start_pos", int'(screen), 23);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_screen", int'(screen), 23);
    check("reset_winner", int'(winner), 0);
    check("reset_playing", int'(playing), 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // First game with exact countdown timing: start sampled at edge k, CD3 from k+2.
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("cd3_entry", int'(screen), 34);
    repeat (15) @(posedge clk);
    #1 check("go_last", int'(screen), 31);
    @(posedge clk);
    #1;
    check("play_entry_screen", int'(screen), 23);
    check("play_entry_playing", int'(playing), 1);

    press(1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("both_no_move", int'(screen), 23);

    @(negedge clk) p2_btn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("latency_before", int'(screen), 23);
    @(posedge clk);
    #1 check("latency_after", int'(screen), 24);
    repeat (18) @(negedge clk);
    p2_btn = 1'b0;
    check("held_single_step", int'(screen), 24);

    press(1'b1, 1'b0, 1'b0);
    check("p1_step", int'(screen), 23);
    repeat (7) press(1'b1, 1'b0, 1'b0);
    check("p1_win_screen", int'(screen), 16);
    check("p1_win_winner", int'(winner), 1);
    check("p1_win_playing", int'(playing), 0);
    repeat (10) @(posedge clk);
    #1;
    check("p1_auto_idle_screen", int'(screen), 23);
    check("p1_auto_idle_winner", int'(winner), 0);

    start_game(1'b1);
    press(1'b0, 1'b0, 1'b1);
    check("start_in_play", int'(screen), 23);
    check("start_in_play_playing", int'(playing), 1);
    repeat (7) press(1'b0, 1'b1, 1'b0);
    check("p2_win_screen", int'(screen), 30);
    check("p2_win_winner", int'(winner), 2);
    repeat (7) @(posedge clk);
    #1 check("p2_hold_last", int'(screen), 30);
    @(posedge clk);
    #1;
    check("p2_auto_idle_screen", int'(screen), 23);
    check("p2_auto_idle_winner", int'(winner), 0);

    start_game(1'b0);
    repeat (7) press(1'b0, 1'b1, 1'b0);
    check("p2_win_again", int'(winner), 2);
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("early_exit_screen", int'(screen), 23);
    check("early_exit_winner", int'(winner), 0);

    start_game(1'b0);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    check("pre_reset_pos", int'(screen), 20);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_screen", int'(screen), 23);
    check("async_reset_winner", int'(winner), 0);
    check("async_reset_playing", int'(playing), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_screen", int'(screen), 23);
    check("post_reset_playing", int'(playing), 0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
